// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO.
// Framing errors and overrun are reported as sticky flags cleared by err_clr.
module uart_rx_fifo #(
  parameter int OVS_DIV    = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS_DIV - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state, state_n;
  logic [1:0]      rst_pipe;
  logic            rst_n;
  logic            rx_meta, rxs;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      samp_cnt;
  logic            tick, samp_due;
  logic            do_shift, do_push, set_ferr;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            pop, push_ok, drop;

  // Reset asserts immediately but releases on a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Start bit is sampled at its centre (8 ticks), later bits every 16 ticks.
  assign tick     = (tick_cnt == TICK_LAST);
  assign samp_due = tick && (samp_cnt == ((state == S_START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_cnt <= samp_due ? 4'd0 : samp_cnt + 4'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_n  = state;
    do_shift = 1'b0;
    do_push  = 1'b0;
    set_ferr = 1'b0;
    case (state)
      S_IDLE:  if (!rxs) state_n = S_START;
      S_START: if (samp_due) state_n = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (samp_due) begin
          do_shift = 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (samp_due) begin
          if (rxs) begin
            do_push = 1'b1;
            state_n = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: if (rxs) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      if (state == S_START) bit_idx <= '0;
      if (do_shift) begin
        shreg[bit_idx] <= rxs;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop     = rd_en && (count != '0);
  assign push_ok = do_push && ((count != FULL) || pop);
  assign drop    = do_push && !push_ok;

  // NOTE: the storage array has no reset; rx_valid/count qualify its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rx_valid   = (count != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

  // A set event in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_ferr)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (drop)         overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and random
// frames checked against a queue-based model of the receive FIFO and flags.
module tb_uart_rx_fifo;

  localparam int OVS       = 2;
  localparam int DEPTH     = 8;
  localparam int BIT_CLK   = 16 * OVS;
  // Negedges from the start-bit edge to the cycle whose rising edge samples the stop bit.
  localparam int PUSH_WAIT = 2 + 152 * OVS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_fifo #(.OVS_DIV(OVS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd;
    logic       clr;
    logic [7:0] exp_head;
    logic       exp_valid;
    int         exp_count;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       m_ferr, m_ovr;
  vec_t       tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    idle(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(BIT_CLK);
    end
    rxd = stop_bit;
    idle(BIT_CLK);
    rxd = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_bit);
    if (!stop_bit)              m_ferr = 1'b1;
    else if (q.size() < DEPTH)  q.push_back(d);
    else                        m_ovr = 1'b1;
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rxd = 1'b1;
    rd_en = 1'b0;
    err_clr = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(4);
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    if (q.size() > 0) check({tag, ".data"}, rx_data, q[0]);
    check({tag, ".valid"}, rx_valid, q.size() > 0);
    check({tag, ".count"}, fifo_count, q.size());
    check({tag, ".ferr"}, frame_err, m_ferr);
    check({tag, ".ovr"}, overrun, m_ovr);
    check({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1, 1'b0, 1'b0};
    tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 2, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 2, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0};
    tbl[6] = '{8'h6E, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 2, 1'b0, 1'b0};
    tbl[7] = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h6E, 1'b1, 1, 1'b1, 1'b0};
    tbl[8] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1, 1'b1, 1'b0};

    do_reset();
    check("rst.data", rx_data, 8'h00);
    check_all("rst");

    // Table of single frames with the action taken after each check.
    foreach (tbl[i]) begin
      send_frame(tbl[i].data, tbl[i].stop);
      idle(6);
      check($sformatf("tbl%0d.data", i), rx_data, tbl[i].exp_head);
      check($sformatf("tbl%0d.valid", i), rx_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d.count", i), fifo_count, tbl[i].exp_count);
      check($sformatf("tbl%0d.ferr", i), frame_err, tbl[i].exp_ferr);
      check($sformatf("tbl%0d.ovr", i), overrun, tbl[i].exp_ovr);
      if (tbl[i].rd) begin
        read_one();
        check($sformatf("tbl%0d.popcount", i), fifo_count, tbl[i].exp_count - 1);
      end
      if (tbl[i].clr) clear_err();
    end

    // Nine back-to-back frames with no reads: the ninth is dropped.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
      model_frame(8'(i), 1'b1);
    end
    idle(6);
    check_all("ovr.full");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr.rd%0d", i), rx_data, q[0]);
      read_one();
    end
    read_one();
    check_all("ovr.drained");
    clear_err();
    check_all("ovr.cleared");

    // Short low glitch on an idle line is rejected.
    rxd = 1'b0;
    idle(10);
    rxd = 1'b1;
    idle(40);
    check_all("glitch");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    idle(6);
    check_all("glitch.3c");

    // Bad stop bit, then a held-low line giving exactly one error event.
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    idle(6);
    check_all("ferr");
    clear_err();
    rxd = 1'b0;
    idle(400);
    check("hold.ferr", frame_err, 1'b1);
    check("hold.busy", busy, 1'b1);
    clear_err();
    idle(99);
    check("hold.ferr_once", frame_err, 1'b0);
    check("hold.busy_low", busy, 1'b1);
    check("hold.count", fifo_count, q.size());
    rxd = 1'b1;
    idle(6);
    check_all("hold.release");

    // Full FIFO with a pop on the exact push cycle of the ninth byte.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      model_frame(8'h10 + 8'(i), 1'b1);
    end
    idle(6);
    check_all("sim.full");
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (PUSH_WAIT) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h77);
    idle(6);
    check_all("sim.after");
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("sim.rd%0d", i), rx_data, q[0]);
      read_one();
    end

    // Reset in the middle of a frame clears FIFO and flags.
    send_frame(8'h99, 1'b1);
    send_frame(8'h55, 1'b0);
    idle(6);
    rxd = 1'b0;
    idle(3 * BIT_CLK);
    reset_n = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check("mid.data", rx_data, 8'h00);
    check_all("mid.rst");
    send_frame(8'h12, 1'b1);
    model_frame(8'h12, 1'b1);
    idle(6);
    check_all("mid.12");

    // Random frames, reads and clears against the model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       s;
      int         nr;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, s);
      model_frame(d, s);
      idle(6);
      check_all($sformatf("rnd%0d", i));
      nr = $urandom_range(0, (i < 12) ? 1 : 3);
      for (int k = 0; k < nr; k++) begin
        if (q.size() > 0) check($sformatf("rnd%0d.rd%0d", i, k), rx_data, q[0]);
        read_one();
      end
      check($sformatf("rnd%0d.cnt", i), fifo_count, q.size());
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive stage feeding the ARM system's memory-mapped I/O. Deserialises the board UART_RXD line (8N1, LSB first) using 16x oversampling.
- Received bytes are buffered in a small show-ahead FIFO that the CPU-side peripheral decoder drains.
- Reports framing errors and overrun as sticky status bits that the CPU can read and clear.

Parameters:
- OVS_DIV, 15, clk cycles per 1/16 bit period (27 MHz / (115200*16), rounded); must be >= 1.
- FIFO_DEPTH, 8, number of byte entries; power of two, >= 2.

Ports:
- clk  input  1  system clock (CLOCK_27 domain).
- reset_n  input  1  asynchronous active-low reset (driven from KEY[0]).
- rxd  input  1  raw serial line; asynchronous; idle high.
- rd_en  input  1  single-cycle pop request from CPU-side decoder.
- err_clr  input  1  clears frame_err and overrun.
- rx_data  output  8  FIFO head byte; valid when rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; rx_valid=0, fifo_count=0, rx_data=0.
  - frame_err=0, overrun=0, busy=0.
  - FSM=IDLE; synchroniser flops preset to 1.
- Synchronisation: rxd passes through 2 flops; all logic uses the synchronised value rxs.
- Tick generator:
  - Counter 0..OVS_DIV-1 produces a 1-cycle tick at wrap.
  - Counter restarts at 0 when leaving IDLE.
  - A sample is taken every 16 ticks, and at 8 ticks for the start bit.
- FSM:
  - IDLE: rxs==0 -> START, tick/sample counters cleared, busy=1.
  - START: at tick 8, rxs==1 -> IDLE (glitch rejected, no status change); rxs==0 -> DATA, bit index=0.
  - DATA: every 16 ticks, shift rxs into bit[index]; after bit 7 -> STOP.
  - STOP: at 16 ticks, sample the stop bit.
    - Stop bit 1: push the byte. If the FIFO is full and rd_en is not asserted in the same cycle, drop the byte and set overrun. Then -> IDLE.
    - Stop bit 0: discard the byte, set frame_err, -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line yields exactly one frame_err event.
- Latency: a pushed byte appears on rx_data/rx_valid on the cycle after the stop-bit sample. From the rxd start edge that is 2 (sync) + (8+16*9)*OVS_DIV + 1 cycles.
- FIFO:
  - Show-ahead: rx_data always reflects the oldest entry.
  - rd_en with rx_valid=1 pops on that edge. rd_en while empty is ignored (no underflow; count stays 0).
  - Simultaneous push and pop: both occur and count is unchanged. When full, the pop frees the slot, so the push is accepted and overrun is not set.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH.
- Status:
  - err_clr clears frame_err and overrun on the next edge.
  - A set event and err_clr in the same cycle: set wins.
- Reset mid-frame: partial byte lost, FSM=IDLE. The FIFO and flags are cleared as in reset.

Test Plan (sim with OVS_DIV=2, 32 clk/bit):
- Send 0xA5 (8N1) -> rx_valid=1, rx_data=0xA5, fifo_count=1, frame_err=0. Pulse rd_en -> rx_valid=0, fifo_count=0.
- Send 0x01..0x09 back-to-back, no reads -> fifo_count=8, overrun=1 after 9th stop bit. Eight reads return 0x01..0x08 in order. err_clr -> overrun=0.
- Low glitch of 10 clk on idle line -> FSM returns to IDLE, fifo_count=0, no flags; following 0x3C is received correctly.
- Frame 0x55 with stop bit 0, line then high -> frame_err=1, fifo_count unchanged. Line held low 500 clk -> still a single error event, busy=1 until the line goes high.
- FIFO full (8 entries), rd_en asserted on the exact cycle the 9th byte 0x77 is pushed -> overrun=0, fifo_count=8, last entry 0x77.
- reset_n low mid-DATA of 0xF0 then released -> all outputs at reset values. Next byte 0x12 is received correctly.
